// File: rtl/noisy_signal_gen.sv
// rtl/noisy_signal_gen.sv - triangle/square test waveform with bounded LFSR noise, sample-rate strobed
module noisy_signal_gen #(
  parameter logic [15:0] CLK_DIV    = 16'd4,
  parameter logic [15:0] STEP       = 16'd256,
  parameter logic [4:0]  NOISE_BITS = 5'd8,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enable,
  input  logic        wave_sel,
  output logic        sample_valid,
  output logic [15:0] clean,
  output logic [15:0] noisy
);

  // A divide of 0 behaves as divide-by-1, so the terminal count is 0 in both cases.
  localparam logic [15:0] DIV_LAST   = (CLK_DIV == 16'd0) ? 16'd0 : CLK_DIV - 16'd1;
  // An all-zero Galois LFSR never leaves zero, so substitute a live seed.
  localparam logic [15:0] SEED       = (LFSR_SEED == 16'd0) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;
  localparam logic [15:0] UP_LIMIT   = 16'hFFFF - STEP;
  localparam logic [15:0] SQ_HIGH    = 16'hC000;
  localparam logic [15:0] SQ_LOW     = 16'h4000;
  // Noise is the low N LFSR bits re-centred around zero, carried in 18-bit two's complement.
  localparam logic [17:0] NOISE_MASK = 18'((32'd1 << NOISE_BITS) - 32'd1);
  localparam logic [17:0] NOISE_HALF = 18'(32'd1 << (NOISE_BITS - 5'd1));

  typedef enum logic {
    ST_UP   = 1'b0,
    ST_DOWN = 1'b1
  } tri_state_t;

  logic [15:0] div_cnt;
  logic        strobe;
  tri_state_t  state_q;
  tri_state_t  state_d;
  logic [15:0] level_q;
  logic [15:0] level_d;
  logic [15:0] lfsr_q;
  logic [15:0] lfsr_next;
  logic [15:0] clean_d;
  logic [17:0] noise;
  logic [17:0] sum;
  logic [15:0] noisy_d;

  // A sample is due when the divider sits at its terminal count and the block is running.
  assign strobe = enable && (div_cnt == DIV_LAST);

  // Sample-rate divider; freezes in place while enable is low.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= 16'd0;
    end else if (enable) begin
      if (div_cnt == DIV_LAST) begin
        div_cnt <= 16'd0;
      end else begin
        div_cnt <= div_cnt + 16'd1;
      end
    end
  end

  // Triangle direction and level registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_UP;
      level_q <= 16'd0;
    end else begin
      state_q <= state_d;
      level_q <= level_d;
    end
  end

  // Triangle next-state: clip to the rail and reverse instead of wrapping.
  always_comb begin
    state_d = state_q;
    level_d = level_q;
    if (strobe) begin
      case (state_q)
        ST_UP: begin
          if (level_q > UP_LIMIT) begin
            level_d = 16'hFFFF;
            state_d = ST_DOWN;
          end else begin
            level_d = level_q + STEP;
          end
        end
        ST_DOWN: begin
          if (level_q < STEP) begin
            level_d = 16'd0;
            state_d = ST_UP;
          end else begin
            level_d = level_q - STEP;
          end
        end
        default: begin
          state_d = ST_UP;
          level_d = 16'd0;
        end
      endcase
    end
  end

  // Clean sample from the post-update triangle; the square follows the triangle direction.
  always_comb begin
    clean_d = level_d;
    if (wave_sel) begin
      clean_d = (state_d == ST_UP) ? SQ_HIGH : SQ_LOW;
    end
  end

  // Noise from the pre-advance LFSR, added to the clean sample and clamped to 16 bits.
  always_comb begin
    lfsr_next = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 16'h0000);
    noise     = ({2'b00, lfsr_q} & NOISE_MASK) - NOISE_HALF;
    sum       = {2'b00, clean_d} + noise;
    noisy_d   = sum[15:0];
    if (sum[17]) begin
      noisy_d = 16'h0000;
    end else if (sum[16]) begin
      noisy_d = 16'hFFFF;
    end
  end

  // LFSR advances exactly once per produced sample.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr_q <= SEED;
    end else if (strobe) begin
      lfsr_q <= lfsr_next;
    end
  end

  // Registered outputs: data and valid move together; data holds between strobes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample_valid <= 1'b0;
      clean        <= 16'd0;
      noisy        <= 16'd0;
    end else begin
      sample_valid <= strobe;
      if (strobe) begin
        clean <= clean_d;
        noisy <= noisy_d;
      end
    end
  end

endmodule

// File: doc/noisy_signal_gen.md
# noisy_signal_gen

Stimulus source for the averaging-filter chain. Generates a clean 16-bit unsigned test waveform (triangle or square) and a noisy copy (clean plus bounded LFSR pseudo-noise, saturated) at a programmable sample rate. Each new sample is marked with a one-cycle valid strobe. The `noisy` output drives a moving-average filter input directly. The `clean` output is the golden reference for comparing against filter output.

## Interface
- `CLK_DIV`, default 16'd4: clocks per sample. The value 0 is treated as 1.
- `STEP`, default 16'd256: triangle increment/decrement per sample. Must be nonzero.
- `NOISE_BITS`, default 5'd8: noise width N (1..15). Noise range is [-2^(N-1), 2^(N-1)-1].
- `LFSR_SEED`, default 16'hACE1: LFSR reset value. A seed of 0 is replaced by 16'h0001.
- `reset_n`, in, 1: asynchronous, active-low reset.
- `clk`, in, 1: single clock. All logic runs on the rising edge.
- `enable`, in, 1: run sample generation. When low, the block freezes.
- `wave_sel`, in, 1: 0 selects triangle, 1 selects square. Sampled only on a strobe.
- `sample_valid`, out, 1: one-cycle pulse when `clean`/`noisy` update.
- `clean`, out, 16: current clean sample, unsigned.
- `noisy`, out, 16: current noisy sample, unsigned, saturated.

## Operation
- **Divider**
  - 16-bit counter `div_cnt`.
  - When `enable`=1: if `div_cnt`==CLK_DIV-1, raise an internal strobe and set `div_cnt` to 0; otherwise increment `div_cnt`.
  - When `enable`=0: `div_cnt` holds, no strobe is raised, and all outputs hold.
- **Triangle FSM**
  - States are UP and DOWN. The 16-bit `level` register updates only on a strobe.
  - UP: if `level` > 16'hFFFF-STEP, set `level` to 16'hFFFF and go to DOWN. Otherwise `level` += STEP.
  - DOWN: if `level` < STEP, set `level` to 0 and go to UP. Otherwise `level` -= STEP.
- **Waveform select**
  - Triangle: clean value is the updated `level`.
  - Square: clean value is 16'hC000 if the updated state is UP, 16'h4000 if DOWN. Square period therefore equals the triangle period.
  - `wave_sel` may change at any time. It takes effect on the next strobe, and `level` and the FSM keep running independently of it.
- **Noise**
  - 16-bit Galois LFSR, polynomial x^16+x^14+x^13+x^11+1, tap mask 16'hB400. Shift right; if the old bit0 is 1, XOR the mask in.
  - On a strobe: noise = lfsr[N-1:0] - 2^(N-1), computed from the pre-advance LFSR value. The LFSR then advances exactly one step.
- **Output arithmetic**
  - 18-bit signed sum = clean + noise.
  - Clamp to 0 if negative, to 65535 if greater than 65535.
  - The clamped result is `noisy`.
- **Reset** (asynchronous, also mid-operation)
  - `div_cnt`=0, `level`=0, state=UP, `lfsr`=LFSR_SEED.
  - `clean`=0, `noisy`=0, `sample_valid`=0.
  - Any in-progress sample is discarded.

## Timing
- All outputs are registered.
- On the strobe edge, `clean`, `noisy` and `sample_valid`=1 update together. `sample_valid` returns to 0 on the next edge unless CLK_DIV=1.
- With `enable` held high from the first edge after reset release: `sample_valid` is high after edges CLK_DIV, 2·CLK_DIV, and so on.
- CLK_DIV=1: `sample_valid` is continuously high while `enable`=1, and there is one new sample per clock.
- Deasserting `enable` on a strobe edge: that edge's sample is not produced and the counter freezes at CLK_DIV-1. Re-enabling produces the sample on the first enabled edge.
- Outputs are stable between strobes. Consumers sample `noisy` qualified by `sample_valid`.
- Triangle full period is 2·ceil(65535/STEP) samples. With STEP=256: 256 samples up, 256 down.

## Test plan
- **Reset/first sample.** Defaults, triangle, `enable`=1 after reset.
  - All outputs are 0 through edge 3.
  - At edge 4: `sample_valid`=1, `clean`=256, `noisy`=353 (noise = 16'hE1-128 = 97).
  - `sample_valid`=0 at edge 5.
- **Triangle turn-around.** Run 256 samples.
  - Sample 255 has `clean`=65280.
  - Sample 256 has `clean`=65535, then 65279, and so on down to 255, then 0, then rising again.
  - `noisy` saturates at 65535 and at 0 whenever noise would overflow or underflow.
- **Square select.** `wave_sel`=1 from reset.
  - First sample: `clean`=16'hC000, `noisy`=49249.
  - `clean` switches to 16'h4000 exactly at the sample where the triangle would turn down.
- **Enable gating.** Drop `enable` for 10 cycles mid-interval.
  - No `sample_valid` pulses while low, and outputs are unchanged.
  - The sample sequence resumes identically, with no skipped LFSR steps.
- **CLK_DIV=1 and noise bounds.** CLK_DIV=1, NOISE_BITS=4.
  - `sample_valid` is high every cycle.
  - `noisy`-`clean` stays within [-8,7] wherever `clean` is not near the rails.
  - The LFSR sequence matches the reference model for 1000 samples.
- **Async reset mid-run.** Pulse `reset_n` low between edges.
  - Outputs go to 0 immediately.
  - After release, the first sample again equals `clean`=256, `noisy`=353.
